regfile_wb_arbiter: RTL

//  Write-back arbiter for the single write port of the 32x32 MIPS register file.
//  Two producers share the port: ALU results and memory-load results.

---
 rtl/regfile_wb_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Purpose: write-back arbiter sharing the register-file write port between ALU and load results.
// Latency: entry accepted at edge E is issued at E+1 (Regwrite high after E+1), captured by the regfile at E+2.
// Backpressure: per-source ready = !full && !reset, from occupancy only (no same-cycle pop pass-through).
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_reg/alu_data   ALU write request handshake
//   mem_valid/mem_ready/mem_reg/mem_data   load write request handshake
//   Regwrite, write_register, write_data   registered register-file write port
//   read_register_1/2, hazard_1/2          combinational RAW check against pending writes
//   idle                                   both FIFOs empty and no write in flight
// Build option: define ROUND_ROBIN_EN for alternating grant when both sources are
// waiting; otherwise loads always win over ALU results.
module regfile_wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              Regwrite,
  output logic [ADDR_W-1:0] write_register,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_register_1,
  input  logic [ADDR_W-1:0] read_register_2,
  output logic              hazard_1,
  output logic              hazard_2,
  output logic              idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ALU   = 0;
  localparam int MEM   = 1;

  logic [ADDR_W-1:0] q_reg [2][DEPTH];
  logic [DATA_W-1:0] q_dat [2][DEPTH];
  logic [PTR_W-1:0]  wptr  [2];
  logic [PTR_W-1:0]  rptr  [2];
  logic [CNT_W-1:0]  cnt   [2];

  logic [ADDR_W-1:0] in_reg  [2];
  logic [DATA_W-1:0] in_data [2];
  logic [1:0]        in_valid;
  logic [1:0]        ready;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        nonempty;
  logic              grant_mem;
  logic              sel;

  assign in_valid      = {mem_valid, alu_valid};
  assign in_reg[ALU]   = alu_reg;
  assign in_reg[MEM]   = mem_reg;
  assign in_data[ALU]  = alu_data;
  assign in_data[MEM]  = mem_data;

  // Writes to $zero complete the handshake but are dropped instead of stored.
  always_comb begin
    nonempty = '0;
    ready    = '0;
    push     = '0;
    for (int s = 0; s < 2; s++) begin
      nonempty[s] = (cnt[s] != '0);
      ready[s]    = (cnt[s] != CNT_W'(DEPTH)) && !reset;
      push[s]     = in_valid[s] && ready[s] && (in_reg[s] != '0);
    end
  end

  assign alu_ready = ready[ALU];
  assign mem_ready = ready[MEM];

`ifdef ROUND_ROBIN_EN
  // last_mem: 1 when the most recent grant went to the load FIFO.
  logic last_mem;

  always_comb begin
    if (nonempty[MEM] && nonempty[ALU]) grant_mem = !last_mem;
    else                                grant_mem = nonempty[MEM];
  end

  always_ff @(posedge clk) begin
    if (reset)          last_mem <= 1'b0;
    else if (|nonempty) last_mem <= grant_mem;
  end
`else
  // Loads are older in the pipeline, so they always go first.
  assign grant_mem = nonempty[MEM];
`endif

  assign pop[MEM] = grant_mem;
  assign pop[ALU] = !grant_mem && nonempty[ALU];
  assign sel      = grant_mem;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        wptr[s] <= '0;
        rptr[s] <= '0;
        cnt[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) begin
          q_reg[s][wptr[s]] <= in_reg[s];
          q_dat[s][wptr[s]] <= in_data[s];
          wptr[s]           <= wptr[s] + 1'b1;
        end
        if (pop[s]) rptr[s] <= rptr[s] + 1'b1;
        cnt[s] <= cnt[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
      end
    end
  end

  // Index and data hold their last value when nothing is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      Regwrite       <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
    end else if (|nonempty) begin
      Regwrite       <= 1'b1;
      write_register <= q_reg[sel][rptr[sel]];
      write_data     <= q_dat[sel][rptr[sel]];
    end else begin
      Regwrite       <= 1'b0;
    end
  end

  // An entry slot is live when its distance from the read pointer is below count.
  always_comb begin
    logic [PTR_W-1:0] off;
    off      = '0;
    hazard_1 = 1'b0;
    hazard_2 = 1'b0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        off = PTR_W'(i) - rptr[s];
        if ({1'b0, off} < cnt[s]) begin
          if (q_reg[s][i] == read_register_1) hazard_1 = 1'b1;
          if (q_reg[s][i] == read_register_2) hazard_2 = 1'b1;
        end
      end
    end
    if (Regwrite && (write_register == read_register_1)) hazard_1 = 1'b1;
    if (Regwrite && (write_register == read_register_2)) hazard_2 = 1'b1;
    if (read_register_1 == '0) hazard_1 = 1'b0;
    if (read_register_2 == '0) hazard_2 = 1'b0;
  end

  assign idle = (cnt[ALU] == '0) && (cnt[MEM] == '0) && !Regwrite;

endmodule
